// File: rtl/bch_syndrome_gen.sv
`default_nettype none
// bch_syndrome_gen: serial syndrome generator for BCH(15,5), t=3, over GF(2^4), x^4+x+1.
// Evaluates S1..S6 of a serially received word and streams them in exponent form. Rev 1.0
module bch_syndrome_gen (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  input  logic       in_bit,
  output logic       out_valid,
  output logic [3:0] out_syndrome
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACC  = 2'd1,
    ST_OUT  = 2'd2
  } state_t;

  localparam int         NSYN     = 6;
  localparam logic [3:0] LAST_BIT = 4'd14;
  localparam logic [2:0] LAST_K   = 3'd5;

  state_t     state_q, state_d;
  logic [3:0] acc_q [NSYN];
  logic [3:0] acc_d [NSYN];
  logic [3:0] cnt_q, cnt_d;
  logic [2:0] k_q, k_d;
  logic [2:0] k_next;
  logic       out_valid_q, out_valid_d;
  logic [3:0] out_syn_q, out_syn_d;

  // Multiply by alpha: shift left, fold x^4 back as x+1.
  function automatic logic [3:0] mul_alpha(input logic [3:0] x);
    return {x[2:0], 1'b0} ^ {2'b00, x[3], x[3]};
  endfunction

  function automatic logic [3:0] mul_alpha_pow(input logic [3:0] x, input int n);
    logic [3:0] r;
    r = x;
    for (int i = 0; i < NSYN; i++) begin
      if (i < n) r = mul_alpha(r);
    end
    return r;
  endfunction

  // Integer form to exponent form; the zero element maps to 15.
  function automatic logic [3:0] gf_log(input logic [3:0] x);
    logic [3:0] e;
    case (x)
      4'd1:    e = 4'd0;
      4'd2:    e = 4'd1;
      4'd4:    e = 4'd2;
      4'd8:    e = 4'd3;
      4'd3:    e = 4'd4;
      4'd6:    e = 4'd5;
      4'd12:   e = 4'd6;
      4'd11:   e = 4'd7;
      4'd5:    e = 4'd8;
      4'd10:   e = 4'd9;
      4'd7:    e = 4'd10;
      4'd14:   e = 4'd11;
      4'd15:   e = 4'd12;
      4'd13:   e = 4'd13;
      4'd9:    e = 4'd14;
      default: e = 4'd15;
    endcase
    return e;
  endfunction

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    k_d         = k_q;
    k_next      = k_q + 3'd1;
    out_valid_d = 1'b0;
    out_syn_d   = 4'd0;

    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          for (int j = 0; j < NSYN; j++) acc_d[j] = {3'b000, in_bit};
          cnt_d   = 4'd1;
          state_d = ST_ACC;
        end
      end

      ST_ACC: begin
        if (!in_valid) begin
          for (int j = 0; j < NSYN; j++) acc_d[j] = 4'd0;
          cnt_d   = 4'd0;
          state_d = ST_IDLE;
        end else begin
          for (int j = 0; j < NSYN; j++)
            acc_d[j] = mul_alpha_pow(acc_q[j], j + 1) ^ {3'b000, in_bit};
          if (cnt_q == LAST_BIT) begin
            // S1 is registered on the same edge that absorbs the last bit.
            cnt_d       = 4'd0;
            k_d         = 3'd0;
            out_valid_d = 1'b1;
            out_syn_d   = gf_log(acc_d[0]);
            state_d     = ST_OUT;
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end
      end

      ST_OUT: begin
        if (k_q == LAST_K) begin
          for (int j = 0; j < NSYN; j++) acc_d[j] = 4'd0;
          k_d     = 3'd0;
          state_d = ST_IDLE;
        end else begin
          k_d         = k_next;
          out_valid_d = 1'b1;
          out_syn_d   = gf_log(acc_q[k_next]);
        end
      end

      default: begin
        for (int j = 0; j < NSYN; j++) acc_d[j] = 4'd0;
        cnt_d   = 4'd0;
        k_d     = 3'd0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      for (int j = 0; j < NSYN; j++) acc_q[j] <= 4'd0;
      cnt_q       <= 4'd0;
      k_q         <= 3'd0;
      out_valid_q <= 1'b0;
      out_syn_q   <= 4'd0;
    end else begin
      state_q     <= state_d;
      for (int j = 0; j < NSYN; j++) acc_q[j] <= acc_d[j];
      cnt_q       <= cnt_d;
      k_q         <= k_d;
      out_valid_q <= out_valid_d;
      out_syn_q   <= out_syn_d;
    end
  end

  assign out_valid    = out_valid_q;
  assign out_syndrome = out_syn_q;

endmodule
`default_nettype wire

// File: tb/tb_bch_syndrome_gen.sv
`default_nettype none
// tb_bch_syndrome_gen: table-driven and scoreboard bench for bch_syndrome_gen.
module tb_bch_syndrome_gen;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_bit = 1'b0;
  logic       out_valid;
  logic [3:0] out_syndrome;

  bch_syndrome_gen dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_bit       (in_bit),
    .out_valid    (out_valid),
    .out_syndrome (out_syndrome)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [14:0] word;
    logic [23:0] syn;   // S1 in [23:20] .. S6 in [3:0], exponent form
  } vec_t;

  vec_t       vecs [5];
  logic [3:0] exp_q [$];
  string      name_q [$];
  logic [3:0] alog [15];
  int         n_vec = 0;
  int         n_err = 0;
  logic [3:0] mon_exp;
  string      mon_name;

  task automatic check(input string nm, input logic [3:0] act, input logic [3:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, req);
    end
  endtask

  // Direct evaluation of r(alpha^j) as a sum of powers, then log lookup.
  function automatic logic [3:0] model_syn(input logic [14:0] w, input int j);
    logic [3:0] s;
    logic [3:0] e;
    s = 4'd0;
    for (int i = 0; i < 15; i++)
      if (w[i]) s = s ^ alog[(i * j) % 15];
    e = 4'd15;
    for (int k = 0; k < 15; k++)
      if (s != 4'd0 && alog[k] == s) e = k[3:0];
    return e;
  endfunction

  task automatic push_expected(input logic [23:0] syn, input string tag);
    for (int j = 0; j < 6; j++) begin
      exp_q.push_back(syn[23 - 4*j -: 4]);
      name_q.push_back($sformatf("%s_S%0d", tag, j + 1));
    end
  endtask

  // Drives the first n bits MSB first; for a full frame also checks output latency.
  task automatic send_bits(input logic [14:0] w, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_bit   = w[14 - i];
      if (n == 15 && i == 14) begin
        #1 check("latency_pre", {3'b000, out_valid}, 4'd0);
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
    in_bit   = 1'b0;
    if (n == 15) begin
      #1 check("latency_first", {3'b000, out_valid}, 4'd1);
    end
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 60) begin
      @(negedge clk);
      #1 t++;
    end
    check("drain", {3'b000, exp_q.size() == 0}, 4'd1);
    exp_q.delete();
    name_q.delete();
  endtask

  // Scoreboard monitor: every out_valid cycle consumes one expected syndrome.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (out_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          check("unexpected_out_valid", 4'd1, 4'd0);
        end else begin
          mon_exp  = exp_q.pop_front();
          mon_name = name_q.pop_front();
          check(mon_name, out_syndrome, mon_exp);
        end
      end else begin
        check("idle_out_valid", {3'b000, out_valid}, 4'd0);
        check("idle_syndrome", out_syndrome, 4'd0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running, expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [3:0]  a;
    logic [14:0] rw;
    logic [23:0] rs;

    a = 4'd1;
    for (int e = 0; e < 15; e++) begin
      alog[e] = a;
      a = {a[2:0], 1'b0} ^ (a[3] ? 4'b0011 : 4'b0000);
    end

    vecs[0] = '{word: 15'h0000, syn: 24'hFFFFFF};
    vecs[1] = '{word: 15'h0001, syn: 24'h000000};
    vecs[2] = '{word: 15'h0002, syn: 24'h123456};
    vecs[3] = '{word: 15'h4000, syn: 24'hEDCBA9};
    vecs[4] = '{word: 15'h0003, syn: 24'h48E1AD};

    #1;
    check("reset_out_valid", {3'b000, out_valid}, 4'd0);
    check("reset_syndrome", out_syndrome, 4'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Spec vectors; entries 3 and 4 are sent back to back.
    for (int i = 0; i < 5; i++) begin
      push_expected(vecs[i].syn, $sformatf("vec%0d", i));
      send_bits(vecs[i].word, 15);
      if (i == 3) repeat (5) @(negedge clk);
      else drain();
    end
    repeat (3) @(negedge clk);

    // Random words against the direct-evaluation model.
    for (int r = 0; r < 4; r++) begin
      rw = 15'($urandom);
      for (int j = 0; j < 6; j++) rs[23 - 4*j -: 4] = model_syn(rw, j + 1);
      push_expected(rs, $sformatf("rand%0d", r));
      send_bits(rw, 15);
      drain();
    end

    // Aborted frame: 7 bits then in_valid low; nothing may come out.
    send_bits(15'h7FFF, 7);
    repeat (25) @(negedge clk);
    check("abort_no_output", {3'b000, out_valid}, 4'd0);
    push_expected(24'h123456, "after_abort");
    send_bits(15'h0002, 15);
    drain();
    repeat (3) @(negedge clk);

    // Reset during the third out_valid cycle.
    push_expected(24'hEDCBA9, "pre_reset");
    send_bits(15'h4000, 15);
    @(posedge clk);
    #2;
    @(posedge clk);
    #2 check("third_out_cycle", {3'b000, out_valid}, 4'd1);
    rst_n = 1'b0;
    #1;
    check("async_reset_valid", {3'b000, out_valid}, 4'd0);
    check("async_reset_syndrome", out_syndrome, 4'd0);
    exp_q.delete();
    name_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    check("post_reset_quiet", {3'b000, out_valid}, 4'd0);
    push_expected(24'hFFFFFF, "post_reset_zero");
    send_bits(15'h0000, 15);
    drain();
    repeat (5) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
